// File: rtl/clk_rst_seq.sv
// rtl/clk_rst_seq.sv - programmable clock-enable divider and staggered multi-domain reset sequencer
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   div_ratio  divide value N (0 or 1 selects bypass)
//   soft_rst   synchronous level request to re-run the reset sequence
//   clk_en     one-cycle strobe every N cycles
//   div_out    divided square wave, period 2N
//   rst_out    active-high per-domain resets, bit i drives domain i
//   seq_done   high once every domain has been released
//   seq_state  sequencer state: 0 HOLD, 1 STRETCH, 2 RELEASE, 3 DONE
module clk_rst_seq #(
  parameter int CNT_W       = 8,
  parameter int STRETCH     = 12,
  parameter int NUM_DOM     = 3,
  parameter int GAP         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CNT_W-1:0]   div_ratio,
  input  logic               soft_rst,
  output logic               clk_en,
  output logic               div_out,
  output logic [NUM_DOM-1:0] rst_out,
  output logic               seq_done,
  output logic [1:0]         seq_state
);

  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_STRETCH = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int ST_W  = $clog2(STRETCH + 1);
  localparam int GAP_W = $clog2(GAP + 1);
  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(STRETCH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOM - 1);

  // Reset synchroniser: asserts immediately, deasserts after SYNC_STAGES edges.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

  // Divider. run_q marks the first edge with rst_sync low so the ratio
  // register is loaded there before counting begins.
  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] ratio_q;
  logic             div_q;
  logic             bypass;
  logic             wrap;

  assign bypass  = (ratio_q < CNT_W'(2));
  assign wrap    = bypass || (cnt_q == (ratio_q - CNT_W'(1)));
  assign clk_en  = run_q & wrap;
  assign div_out = div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      ratio_q <= '0;
      div_q   <= 1'b0;
    end else if (rst_sync) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
    end else if (!run_q) begin
      run_q   <= 1'b1;
      ratio_q <= div_ratio;
      cnt_q   <= '0;
    end else if (wrap) begin
      // A new ratio only takes effect at a period boundary.
      ratio_q <= div_ratio;
      cnt_q   <= '0;
      div_q   <= ~div_q;
    end else begin
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Sequencer
  logic [1:0]         state_q;
  logic [ST_W-1:0]    st_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_DOM-1:0] rst_out_q;
  logic               done_q;
  logic [NUM_DOM-1:0] dom_mask;

  always_comb begin
    dom_mask = '0;
    for (int i = 0; i < NUM_DOM; i++) begin
      dom_mask[i] = (IDX_W'(i) == idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_HOLD;
      st_cnt_q  <= '0;
      gap_cnt_q <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
    end else if (rst_sync || soft_rst) begin
      state_q   <= S_HOLD;
      st_cnt_q  <= '0;
      gap_cnt_q <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          state_q  <= S_STRETCH;
          st_cnt_q <= '0;
        end
        S_STRETCH: begin
          if (st_cnt_q == ST_LAST) begin
            rst_out_q[0] <= 1'b0;
            if (NUM_DOM == 1) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_RELEASE;
              idx_q     <= IDX_W'(1);
              gap_cnt_q <= '0;
            end
          end else begin
            st_cnt_q <= st_cnt_q + ST_W'(1);
          end
        end
        S_RELEASE: begin
          if (gap_cnt_q == GAP_LAST) begin
            // Exactly one bit clears per release edge, in index order.
            rst_out_q <= rst_out_q & ~dom_mask;
            gap_cnt_q <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        default: begin
          state_q <= S_DONE;
        end
      endcase
    end
  end

  assign rst_out   = rst_out_q;
  assign seq_done  = done_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb/tb_clk_rst_seq.sv - directed self-checking bench for clk_rst_seq
module tb_clk_rst_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] div_ratio;
  logic       soft_rst;
  logic       clk_en;
  logic       div_out;
  logic [2:0] rst_out;
  logic       seq_done;
  logic [1:0] seq_state;

  int errors;
  int checks;
  int edge_n;
  int r_edge;
  logic exp_div;

  clk_rst_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_ratio (div_ratio),
    .soft_rst  (soft_rst),
    .clk_en    (clk_en),
    .div_out   (div_out),
    .rst_out   (rst_out),
    .seq_done  (seq_done),
    .seq_state (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Expected {rst_out, seq_done, seq_state} k edges after R with 12/4/4 timing.
  function automatic logic [5:0] seq_exp(input int k);
    if (k < 12)      return {3'b111, 1'b0, 2'd1};
    else if (k < 16) return {3'b110, 1'b0, 2'd2};
    else if (k < 20) return {3'b100, 1'b0, 2'd2};
    else             return {3'b000, 1'b1, 2'd3};
  endfunction

  task automatic test_reset;
    checks++; if (rst_out !== 3'b111) begin errors++; $display("FAIL reset_rst_out got=%b exp=111", rst_out); end
    checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL reset_seq_done got=%b exp=0", seq_done); end
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en got=%b exp=0", clk_en); end
    checks++; if (div_out !== 1'b0) begin errors++; $display("FAIL reset_div_out got=%b exp=0", div_out); end
    checks++; if (seq_state !== 2'd0) begin errors++; $display("FAIL reset_seq_state got=%0d exp=0", seq_state); end
  endtask

  task automatic test_power_on;
    logic [5:0] obs;
    rst_n = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick;
      checks++;
      if ({rst_out, seq_state} !== {3'b111, 2'd0}) begin
        errors++; $display("FAIL pre_r_edge%0d got rst_out=%b state=%0d exp rst_out=111 state=0", i, rst_out, seq_state);
      end
    end
    tick;
    checks++;
    if (seq_state !== 2'd1) begin errors++; $display("FAIL edge_r_state got=%0d exp=1", seq_state); end
    r_edge = edge_n;
    for (int k = 1; k <= 22; k++) begin
      tick;
      obs = {rst_out, seq_done, seq_state};
      checks++;
      if (obs !== seq_exp(k)) begin
        errors++; $display("FAIL power_on_r+%0d got=%b exp=%b", k, obs, seq_exp(k));
      end
    end
  endtask

  task automatic test_divider;
    logic exp_en;
    logic wrap_prev;
    int   k0;
    while (((edge_n - r_edge) % 5) != 4) tick;
    k0 = edge_n - r_edge;
    exp_en  = 1'b1;
    exp_div = ((k0 / 5) % 2) == 1;
    checks++;
    if ({clk_en, div_out} !== {exp_en, exp_div}) begin
      errors++; $display("FAIL div_start got en=%b div=%b exp en=%b div=%b", clk_en, div_out, exp_en, exp_div);
    end
    for (int j = 1; j <= 34; j++) begin
      if (j == 13) div_ratio = 8'd3;
      if (j == 25) div_ratio = 8'd0;
      if (j == 29) div_ratio = 8'd1;
      wrap_prev = exp_en;
      tick;
      if (wrap_prev) exp_div = ~exp_div;
      exp_en = (j >= 25) || (j == 5) || (j == 10) || (j == 15) || (j == 18) || (j == 21) || (j == 24);
      checks++;
      if ({clk_en, div_out} !== {exp_en, exp_div}) begin
        errors++; $display("FAIL divider_j%0d got en=%b div=%b exp en=%b div=%b", j, clk_en, div_out, exp_en, exp_div);
      end
    end
  endtask

  task automatic test_soft_rst_done;
    logic [5:0] obs;
    logic [5:0] exp_s;
    logic       wrap_prev;
    checks++;
    if (seq_state !== 2'd3) begin errors++; $display("FAIL soft_done_pre_state got=%0d exp=3", seq_state); end
    div_ratio = 8'd5;
    tick;
    exp_div = ~exp_div;
    checks++;
    if ({clk_en, div_out} !== {1'b0, exp_div}) begin
      errors++; $display("FAIL soft_done_ratio_load got en=%b div=%b exp en=0 div=%b", clk_en, div_out, exp_div);
    end
    soft_rst = 1'b1;
    for (int p = 1; p <= 23; p++) begin
      if (p == 2) soft_rst = 1'b0;
      wrap_prev = (((p - 1) % 5) == 4);
      tick;
      if (wrap_prev) exp_div = ~exp_div;
      obs   = {rst_out, seq_done, seq_state};
      exp_s = (p == 1) ? {3'b111, 1'b0, 2'd0} : seq_exp(p - 2);
      checks++;
      if (obs !== exp_s) begin
        errors++; $display("FAIL soft_done_seq_p%0d got=%b exp=%b", p, obs, exp_s);
      end
      checks++;
      if ({clk_en, div_out} !== {((p % 5) == 4), exp_div}) begin
        errors++; $display("FAIL soft_done_div_p%0d got en=%b div=%b exp en=%b div=%b", p, clk_en, div_out, ((p % 5) == 4), exp_div);
      end
    end
  endtask

  task automatic test_soft_rst_release;
    logic [5:0] obs;
    logic [2:0] prev;
    soft_rst = 1'b1;
    tick;
    soft_rst = 1'b0;
    tick;
    prev = rst_out;
    for (int k = 1; k <= 12; k++) begin
      tick;
      obs = {rst_out, seq_done, seq_state};
      checks++;
      if (obs !== seq_exp(k) || $countones(prev ^ rst_out) > 1) begin
        errors++; $display("FAIL release_pre_r+%0d got=%b exp=%b prev_rst=%b", k, obs, seq_exp(k), prev);
      end
      prev = rst_out;
    end
    soft_rst = 1'b1;
    tick;
    soft_rst = 1'b0;
    obs = {rst_out, seq_done, seq_state};
    checks++;
    if (obs !== {3'b111, 1'b0, 2'd0} || $countones(prev ^ rst_out) > 1) begin
      errors++; $display("FAIL release_abort got=%b exp=111000 prev_rst=%b", obs, prev);
    end
    prev = rst_out;
    tick;
    obs = {rst_out, seq_done, seq_state};
    checks++;
    if (obs !== seq_exp(0)) begin errors++; $display("FAIL release_restart got=%b exp=%b", obs, seq_exp(0)); end
    for (int k = 1; k <= 21; k++) begin
      tick;
      obs = {rst_out, seq_done, seq_state};
      checks++;
      if (obs !== seq_exp(k) || $countones(prev ^ rst_out) > 1) begin
        errors++; $display("FAIL release_rerun_r+%0d got=%b exp=%b prev_rst=%b", k, obs, seq_exp(k), prev);
      end
      prev = rst_out;
    end
  endtask

  task automatic test_rst_mid_stretch;
    logic [5:0] obs;
    logic       exp_d;
    soft_rst = 1'b1;
    tick;
    soft_rst = 1'b0;
    tick;
    for (int i = 0; i < 10 && div_out !== 1'b1; i++) tick;
    checks++;
    if ({seq_state, div_out} !== {2'd1, 1'b1}) begin
      errors++; $display("FAIL mid_stretch_setup got state=%0d div=%b exp state=1 div=1", seq_state, div_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rst_out, seq_done, seq_state, clk_en, div_out} !== {3'b111, 1'b0, 2'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL async_abort got rst=%b done=%b state=%0d en=%b div=%b exp 111/0/0/0/0", rst_out, seq_done, seq_state, clk_en, div_out);
    end
    tick;
    tick;
    checks++;
    if ({rst_out, seq_done, seq_state, clk_en, div_out} !== {3'b111, 1'b0, 2'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL held_in_reset got rst=%b done=%b state=%0d en=%b div=%b exp 111/0/0/0/0", rst_out, seq_done, seq_state, clk_en, div_out);
    end
    rst_n = 1'b1;
    tick;
    tick;
    checks++;
    if (seq_state !== 2'd0) begin errors++; $display("FAIL rerelease_pre_r got=%0d exp=0", seq_state); end
    tick;
    checks++;
    if (seq_state !== 2'd1) begin errors++; $display("FAIL rerelease_edge_r got=%0d exp=1", seq_state); end
    r_edge = edge_n;
    for (int k = 1; k <= 21; k++) begin
      tick;
      obs   = {rst_out, seq_done, seq_state};
      exp_d = ((k / 5) % 2) == 1;
      checks++;
      if (obs !== seq_exp(k)) begin
        errors++; $display("FAIL rerelease_seq_r+%0d got=%b exp=%b", k, obs, seq_exp(k));
      end
      checks++;
      if ({clk_en, div_out} !== {((k % 5) == 4), exp_d}) begin
        errors++; $display("FAIL rerelease_div_r+%0d got en=%b div=%b exp en=%b div=%b", k, clk_en, div_out, ((k % 5) == 4), exp_d);
      end
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    edge_n    = 0;
    r_edge    = 0;
    exp_div   = 1'b0;
    rst_n     = 1'b0;
    soft_rst  = 1'b0;
    div_ratio = 8'd5;
    tick;
    tick;
    test_reset;
    test_power_on;
    test_divider;
    test_soft_rst_done;
    test_soft_rst_release;
    test_rst_mid_stretch;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
